data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares the single per-core data memory between two requesters:
  - the pipeline MEM1 stage (load/store);
  - a host/debug port (valid/ready handshake).
- The pipeline has priority. A wait counter guarantees host forward progress by stalling the pipeline for one cycle after the host has waited MAX_WAIT cycles.
- Sits between mem1_stage's data-memory interface and the memory array.
- Returns host read data with a registered response valid.

Parameters:
- DATA_WIDTH, 64, memory word width.
- THREAD_INDEX_BITS, 3, thread-index field of the address.
- DATA_MEM_ADDR_BITS, 8, per-thread word address bits.
- MAX_WAIT, 4, consecutive denied host cycles before the host is forced through (0 = host always wins).

Ports:
- A = THREAD_INDEX_BITS+DATA_MEM_ADDR_BITS.
- clk in 1: single clock, all state on rising edge.
- reset in 1: synchronous, active-high.
- pipe_re in 1: pipeline load this cycle.
- pipe_we in 1: pipeline store this cycle.
- pipe_addr in A: pipeline word address {thread, word}.
- pipe_wdata in DATA_WIDTH: pipeline store data.
- pipe_rdata out DATA_WIDTH: pipeline load data (mem_rdata passthrough).
- pipe_stall out 1: pipeline access denied this cycle; hold request.
- host_valid in 1: host request present.
- host_we in 1: host request is a write.
- host_addr in A: host word address.
- host_wdata in DATA_WIDTH: host write data.
- host_ready out 1: host request accepted this cycle.
- host_rvalid out 1: host read data valid.
- host_rdata out DATA_WIDTH: host read data.
- mem_raddr out A: memory read address.
- mem_rdata in DATA_WIDTH: memory read data, 1-cycle synchronous read.
- mem_waddr out A: memory write address.
- mem_wdata out DATA_WIDTH: memory write data.
- mem_we out 1: memory write enable.

Behaviour:

Memory model:
- Synchronous read: data for mem_raddr presented in cycle N appears on mem_rdata in N+1.
- Write commits at the end of cycle N.

Arbitration (combinational from inputs plus registered wait_cnt):
- pipe_active = pipe_re | pipe_we.
- host_grant = host_valid & (~pipe_active | (wait_cnt == MAX_WAIT)).
- host_ready = host_grant.
- pipe_stall = pipe_active & host_grant.

Memory port mux:
- host_grant=1: mem_raddr = mem_waddr = host_addr; mem_wdata = host_wdata; mem_we = host_we.
- Otherwise: mem_raddr = mem_waddr = pipe_addr; mem_wdata = pipe_wdata; mem_we = pipe_we & ~pipe_re.
- pipe_re and pipe_we both high: treat as a load, no write.

wait_cnt (width $clog2(MAX_WAIT+1)):
- Reset 0.
- Clears to 0 on host_grant or ~host_valid.
- Otherwise increments, saturating at MAX_WAIT.

Starvation bound:
- A continuously valid host is accepted at most MAX_WAIT+1 cycles after it first asserts.
- The pipeline is never stalled twice in a row: after a forced grant, wait_cnt=0.

Host read response:
- host_rvalid is a register: next value = host_grant & ~host_we.
- host_rdata = host_rvalid ? mem_rdata : 0.
- A host read accepted in cycle N returns in N+1.
- Back-to-back host reads are allowed: one response per cycle, in order.

Pipeline read data:
- pipe_rdata = mem_rdata unconditionally.
- The pipeline uses it only in the cycle after an un-stalled pipe_re.

Host handshake:
- The host must hold host_we/host_addr/host_wdata stable while host_valid=1 and host_ready=0.
- Dropping host_valid before ready is legal and clears wait_cnt.

Reset values:
- wait_cnt=0, host_rvalid=0, host_rdata=0.
- While reset=1: host_ready=0, pipe_stall=0, mem_we=0.
- Reset mid-operation: a host read accepted in the cycle before reset produces no host_rvalid, and its response is discarded.

Simultaneous same-address events:
- Impossible within a cycle (one grant per cycle).
- Across cycles, ordering is grant order: a write in N is visible to a read granted in N+1.

Test Plan:
1. Pipeline only: pipe_we=1, addr 0x005, wdata 0xAAAA; next cycle pipe_re=1, addr 0x005 -> mem_we=1 in the first cycle; pipe_rdata=0xAAAA one cycle after the read; pipe_stall never asserted.
2. Idle pipeline with host read 0x105 (0x1234 preloaded) -> host_ready=1 in the same cycle; host_rvalid=1 with host_rdata=0x1234 in the next cycle only, then host_rvalid=0.
3. Starvation, MAX_WAIT=4: pipe_re held high and host_valid write 0x0FF ← 0xBEEF from cycle 0 -> host_ready=0 for cycles 0–3, host_ready=1 and pipe_stall=1 at cycle 4, mem_we=1 with mem_waddr=0x0FF; cycle 5 pipe_stall=0; a second host request again waits 4 cycles.
4. Back-to-back host reads 0x010, 0x011, 0x012 with the pipeline idle -> three consecutive host_rvalid pulses with the data in order; wait_cnt stays 0.
5. Host read granted at cycle N with reset=1 at N+1 -> host_rvalid=0 at N+1 and N+2; wait_cnt=0; no mem_we during reset even if pipe_we=1.
6. Host valid drops after 2 denied cycles, then reasserts with pipe_we continuously high -> wait_cnt restarts from 0; grant occurs 4 cycles after reassertion.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//
// Shares one per-core data memory between the pipeline MEM1 stage and a
// host/debug port. The pipeline has priority. A wait counter forces the host
// through after it has been denied MAX_WAIT consecutive cycles, and that
// stalls the pipeline for one cycle.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   pipe_re/we/addr/wdata      pipeline load/store request
//   pipe_rdata                 pipeline load data (mem_rdata passthrough)
//   pipe_stall                 pipeline denied this cycle, hold request
//   host_valid/we/addr/wdata   host request (valid/ready handshake)
//   host_ready                 host request accepted this cycle
//   host_rvalid/rdata          host read response, one cycle after accept
//   mem_raddr/waddr/wdata/we   memory array port (1-cycle synchronous read)
//   mem_rdata                  memory read data
module data_mem_arbiter #(
    parameter int unsigned DATA_WIDTH         = 64,
    parameter int unsigned THREAD_INDEX_BITS  = 3,
    parameter int unsigned DATA_MEM_ADDR_BITS = 8,
    parameter int unsigned MAX_WAIT           = 4
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          pipe_re,
    input  logic                                          pipe_we,
    input  logic [THREAD_INDEX_BITS+DATA_MEM_ADDR_BITS-1:0] pipe_addr,
    input  logic [DATA_WIDTH-1:0]                         pipe_wdata,
    output logic [DATA_WIDTH-1:0]                         pipe_rdata,
    output logic                                          pipe_stall,
    input  logic                                          host_valid,
    input  logic                                          host_we,
    input  logic [THREAD_INDEX_BITS+DATA_MEM_ADDR_BITS-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0]                         host_wdata,
    output logic                                          host_ready,
    output logic                                          host_rvalid,
    output logic [DATA_WIDTH-1:0]                         host_rdata,
    output logic [THREAD_INDEX_BITS+DATA_MEM_ADDR_BITS-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0]                         mem_rdata,
    output logic [THREAD_INDEX_BITS+DATA_MEM_ADDR_BITS-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0]                         mem_wdata,
    output logic                                          mem_we
);

    // MAX_WAIT = 0 would give a zero-width counter; keep one bit that stays 0.
    localparam int unsigned    CntW   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_WAIT);

    logic            pipe_active;
    logic            host_grant;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            rvalid_q, rvalid_d;

    // Arbitration. Reset gates the grant so nothing reaches memory while held.
    always_comb begin
        pipe_active = pipe_re | pipe_we;
        host_grant  = ~reset & host_valid & (~pipe_active | (wait_cnt_q == MaxCnt));
        host_ready  = host_grant;
        pipe_stall  = pipe_active & host_grant;
    end

    // Memory port mux. A simultaneous load and store is treated as a load.
    always_comb begin
        if (host_grant) begin
            mem_raddr = host_addr;
            mem_waddr = host_addr;
            mem_wdata = host_wdata;
            mem_we    = host_we;
        end else begin
            mem_raddr = pipe_addr;
            mem_waddr = pipe_addr;
            mem_wdata = pipe_wdata;
            mem_we    = ~reset & pipe_we & ~pipe_re;
        end
    end

    // Count consecutive denied host cycles, saturating at MAX_WAIT.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (host_grant || !host_valid) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != MaxCnt) begin
            wait_cnt_d = wait_cnt_q + CntW'(1);
        end
        rvalid_d = host_grant & ~host_we;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rvalid_q   <= rvalid_d;
        end
    end

    // Masking with reset drops a response whose read was accepted just before
    // reset asserted.
    always_comb begin
        pipe_rdata  = mem_rdata;
        host_rvalid = rvalid_q & ~reset;
        host_rdata  = host_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic          pipe_re, pipe_we;
    logic [AW-1:0] pipe_addr;
    logic [DW-1:0] pipe_wdata, pipe_rdata;
    logic          pipe_stall;
    logic          host_valid, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ready, host_rvalid;
    logic [DW-1:0] host_rdata;
    logic [AW-1:0] mem_raddr, mem_waddr;
    logic [DW-1:0] mem_rdata, mem_wdata;
    logic          mem_we;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(
        .DATA_WIDTH(64), .THREAD_INDEX_BITS(3), .DATA_MEM_ADDR_BITS(8), .MAX_WAIT(4)
    ) dut (
        .clk(clk), .reset(reset),
        .pipe_re(pipe_re), .pipe_we(pipe_we), .pipe_addr(pipe_addr),
        .pipe_wdata(pipe_wdata), .pipe_rdata(pipe_rdata), .pipe_stall(pipe_stall),
        .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ready(host_ready), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_we(mem_we)
    );

    // Memory array: synchronous read, write commits at the clock edge.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        mem_rdata <= mem[mem_raddr];
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Move to the next cycle: inputs change 1 time unit after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #2;
    endtask

    task automatic idle();
        pipe_re = 0; pipe_we = 0; pipe_addr = '0; pipe_wdata = '0;
        host_valid = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    endtask

    task automatic host_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        host_valid = 1; host_we = we; host_addr = a; host_wdata = d;
    endtask

    initial begin
        idle();
        reset = 1;
        // Reset state, with requests pending that must be ignored.
        next_cycle();
        pipe_we = 1; pipe_addr = 11'h005; pipe_wdata = 64'hDEAD;
        host_req(1'b0, 11'h105, '0);
        settle();
        check("rst_host_ready", host_ready, 0);
        check("rst_pipe_stall", pipe_stall, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_host_rvalid", host_rvalid, 0);
        check("rst_host_rdata", host_rdata, 0);
        next_cycle();
        idle();
        reset = 0;

        // 1. Pipeline store then load.
        pipe_we = 1; pipe_addr = 11'h005; pipe_wdata = 64'hAAAA;
        settle();
        check("t1_mem_we_store", mem_we, 1);
        check("t1_mem_waddr", mem_waddr, 11'h005);
        check("t1_stall_store", pipe_stall, 0);
        next_cycle();
        pipe_we = 0; pipe_re = 1;
        settle();
        check("t1_mem_we_load", mem_we, 0);
        check("t1_stall_load", pipe_stall, 0);
        next_cycle();
        // Load and store together behaves as a load.
        pipe_re = 1; pipe_we = 1; pipe_wdata = 64'h5555;
        settle();
        check("t1_pipe_rdata", pipe_rdata, 64'hAAAA);
        check("t1_host_rdata_idle", host_rdata, 0);
        check("t1_re_we_no_write", mem_we, 0);
        next_cycle();
        idle();
        settle();
        check("t1_re_we_rdata", pipe_rdata, 64'hAAAA);

        // Preload through host writes with the pipeline idle.
        next_cycle();
        host_req(1'b1, 11'h105, 64'h1234);
        settle();
        check("pre_ready", host_ready, 1);
        check("pre_mem_we", mem_we, 1);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            host_req(1'b1, AW'(11'h010 + i), DW'(64'h10 + i));
            settle();
            check("pre_ready_seq", host_ready, 1);
        end
        next_cycle();
        idle();
        settle();
        check("pre_no_rvalid_after_write", host_rvalid, 0);

        // 2. Single host read with idle pipeline.
        next_cycle();
        host_req(1'b0, 11'h105, '0);
        settle();
        check("t2_ready", host_ready, 1);
        check("t2_rvalid_same", host_rvalid, 0);
        next_cycle();
        idle();
        settle();
        check("t2_rvalid", host_rvalid, 1);
        check("t2_rdata", host_rdata, 64'h1234);
        next_cycle();
        settle();
        check("t2_rvalid_drop", host_rvalid, 0);
        check("t2_rdata_zero", host_rdata, 0);

        // 3. Starvation bound with the pipeline loading continuously.
        next_cycle();
        pipe_re = 1; pipe_addr = 11'h020;
        host_req(1'b1, 11'h0FF, 64'hBEEF);
        for (int c = 0; c < 4; c++) begin
            settle();
            check("t3_denied", host_ready, 0);
            check("t3_no_stall", pipe_stall, 0);
            next_cycle();
        end
        settle();
        check("t3_forced_ready", host_ready, 1);
        check("t3_forced_stall", pipe_stall, 1);
        check("t3_forced_we", mem_we, 1);
        check("t3_forced_waddr", mem_waddr, 11'h0FF);
        check("t3_forced_wdata", mem_wdata, 64'hBEEF);
        next_cycle();
        host_req(1'b1, 11'h0FE, 64'hCAFE);
        settle();
        check("t3_stall_not_twice", pipe_stall, 0);
        check("t3_second_denied0", host_ready, 0);
        for (int c = 1; c < 4; c++) begin
            next_cycle();
            settle();
            check("t3_second_denied", host_ready, 0);
        end
        next_cycle();
        settle();
        check("t3_second_ready", host_ready, 1);
        check("t3_second_stall", pipe_stall, 1);
        next_cycle();
        idle();
        host_req(1'b0, 11'h0FF, '0);
        settle();
        check("t3_readback_ready", host_ready, 1);
        next_cycle();
        idle();
        settle();
        check("t3_readback_data", host_rdata, 64'hBEEF);

        // 4. Back-to-back host reads.
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            host_req(1'b0, AW'(11'h010 + i), '0);
            settle();
            check("t4_ready", host_ready, 1);
            if (i > 0) begin
                check("t4_rvalid", host_rvalid, 1);
                check("t4_rdata", host_rdata, DW'(64'h10 + i - 1));
            end
            next_cycle();
        end
        idle();
        settle();
        check("t4_rvalid_last", host_rvalid, 1);
        check("t4_rdata_last", host_rdata, 64'h12);
        next_cycle();
        settle();
        check("t4_rvalid_end", host_rvalid, 0);

        // 5. Reset right after a host read is accepted.
        host_req(1'b0, 11'h105, '0);
        settle();
        check("t5_ready", host_ready, 1);
        next_cycle();
        idle();
        reset = 1;
        pipe_we = 1; pipe_addr = 11'h105; pipe_wdata = 64'hDEAD;
        settle();
        check("t5_rvalid_in_reset", host_rvalid, 0);
        check("t5_rdata_in_reset", host_rdata, 0);
        check("t5_mem_we_in_reset", mem_we, 0);
        next_cycle();
        idle();
        reset = 0;
        settle();
        check("t5_rvalid_after", host_rvalid, 0);

        // 6. Host drops valid after two denials, then reasserts.
        next_cycle();
        pipe_we = 1; pipe_addr = 11'h030; pipe_wdata = 64'h77;
        host_req(1'b0, 11'h105, '0);
        for (int c = 0; c < 2; c++) begin
            settle();
            check("t6_pre_denied", host_ready, 0);
            next_cycle();
        end
        host_valid = 0;
        settle();
        check("t6_dropped_we", mem_we, 1);
        next_cycle();
        host_valid = 1;
        for (int c = 0; c < 4; c++) begin
            settle();
            check("t6_denied", host_ready, 0);
            next_cycle();
        end
        settle();
        check("t6_ready", host_ready, 1);
        check("t6_stall", pipe_stall, 1);
        next_cycle();
        idle();
        settle();
        check("t6_rvalid", host_rvalid, 1);
        check("t6_rdata_unchanged", host_rdata, 64'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
